// File: rtl/gyro_pkg.sv
// Shared types and constants for the gyro rate integrator.
package gyro_pkg;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_CAL  = 2'd1,
        ST_LOAD = 2'd2
    } gyro_state_e;

    localparam int GAIN_W = 16;

    function automatic int acc_width(input int out_w, input int frac_bits);
        return out_w + frac_bits;
    endfunction

endpackage

// File: rtl/gyro_chan.sv
// One integrator channel: bias register, calibration sum, S1/S2 pipeline, accumulator and angle register.
// Optional build macro GYRO_DEADBAND_EN zeroes small bias-corrected rates in S1.
module gyro_chan
    import gyro_pkg::*;
#(
    parameter int IN_W       = 16,
    parameter int OUT_W      = 16,
    parameter int FRAC_BITS  = 8,
    parameter int GAIN       = 6554,
    parameter int GAIN_SHIFT = 16,
    parameter int CAL_LOG2   = 4,
    parameter int DEADBAND   = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IN_W-1:0]  rate,
    input  logic             add_en,
    input  logic             acc_clr,
    input  logic             cal_clr,
    input  logic             cal_add,
    input  logic             bias_load,
    input  logic             out_upd,
    input  logic             out_clr,
    output logic [OUT_W-1:0] angle
);

    localparam int ACC_W  = acc_width(OUT_W, FRAC_BITS);
    localparam int D_W    = IN_W + 1;
    localparam int PROD_W = D_W + GAIN_W + 1;
    localparam int SUM_W  = IN_W + CAL_LOG2;
    localparam int SHIFT  = GAIN_SHIFT - FRAC_BITS;

    if (GAIN_SHIFT < FRAC_BITS) begin : g_bad_shift
        $error("gyro_chan: GAIN_SHIFT must be >= FRAC_BITS");
    end
    if (DEADBAND < 0) begin : g_bad_deadband
        $error("gyro_chan: DEADBAND must be non-negative");
    end

    logic signed [IN_W-1:0]   bias_r;
    logic signed [SUM_W-1:0]  sum_r;
    logic signed [D_W-1:0]    d_r;
    logic        [ACC_W-1:0]  acc_r;
    logic        [OUT_W-1:0]  angle_r;
    logic signed [D_W-1:0]    diff_s;
    logic signed [D_W-1:0]    d_next_s;
    logic signed [PROD_W-1:0] prod_s;
    logic        [ACC_W-1:0]  inc_s;
`ifdef GYRO_DEADBAND_EN
    logic        [D_W-1:0]    mag_s;
`endif

    // S1 operand: bias-corrected rate, one bit wider so it cannot overflow
    always_comb begin
        diff_s   = D_W'($signed(rate)) - D_W'(bias_r);
        d_next_s = diff_s;
`ifdef GYRO_DEADBAND_EN
        mag_s = diff_s[D_W-1] ? -diff_s : diff_s;
        if (mag_s <= D_W'(DEADBAND)) begin
            d_next_s = '0;
        end else begin
            d_next_s = diff_s;
        end
`endif
    end

    // S2 operand: full-width product, then floor shift down to accumulator scale
    always_comb begin
        prod_s = PROD_W'(d_r) * PROD_W'(GAIN);
        inc_s  = ACC_W'(prod_s >>> SHIFT);
    end

    // Channel state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_r     <= '0;
            sum_r   <= '0;
            bias_r  <= '0;
            acc_r   <= '0;
            angle_r <= '0;
        end else begin
            d_r <= d_next_s;
            if (cal_clr) begin
                sum_r <= '0;
            end else if (cal_add) begin
                sum_r <= sum_r + SUM_W'($signed(rate));
            end
            if (bias_load) begin
                bias_r <= IN_W'(sum_r >>> CAL_LOG2);
            end
            if (acc_clr) begin
                acc_r <= '0;
            end else if (add_en) begin
                acc_r <= acc_r + inc_s;
            end
            if (out_clr) begin
                angle_r <= '0;
            end else if (out_upd) begin
                angle_r <= acc_r[FRAC_BITS +: OUT_W];
            end
        end
    end

    assign angle = angle_r;

endmodule

// File: rtl/gyro_integrator.sv
// Multi-channel gyro rate integrator with bias calibration FSM and re-zero command.
// Optional build macro GYRO_DEADBAND_EN enables the rate deadband in every channel.
module gyro_integrator
    import gyro_pkg::*;
#(
    parameter int NUM_CH     = 3,
    parameter int IN_W       = 16,
    parameter int OUT_W      = 16,
    parameter int FRAC_BITS  = 8,
    parameter int GAIN       = 6554,
    parameter int GAIN_SHIFT = 16,
    parameter int CAL_LOG2   = 4,
    parameter int DEADBAND   = 2
) (
    input  logic                    clk_100mhz,
    input  logic                    rst_n_in,
    input  logic [NUM_CH*IN_W-1:0]  rate_in,
    input  logic                    rate_valid_in,
    input  logic                    cal_start_in,
    input  logic                    zero_in,
    output logic [NUM_CH*OUT_W-1:0] angle_out,
    output logic                    angle_valid_out,
    output logic                    ready_out,
    output logic                    cal_busy_out
);

    localparam logic [CAL_LOG2-1:0] CNT_LAST = '1;

    gyro_state_e         state_r;
    gyro_state_e         state_next_s;
    logic [CAL_LOG2-1:0] cnt_r;
    logic                v1_r;
    logic                v2_r;
    logic                valid_r;
    logic                ready_r;
    logic                busy_r;
    logic                accept_s;
    logic                flow_s;
    logic                cal_go_s;
    logic                zero_go_s;
    logic                cal_add_s;
    logic                load_s;

    // Next state and per-cycle channel controls; calibration outranks re-zero
    always_comb begin
        state_next_s = state_r;
        accept_s     = 1'b0;
        flow_s       = 1'b0;
        cal_go_s     = 1'b0;
        zero_go_s    = 1'b0;
        cal_add_s    = 1'b0;
        load_s       = 1'b0;
        case (state_r)
            ST_RUN: begin
                if (cal_start_in) begin
                    cal_go_s     = 1'b1;
                    state_next_s = ST_CAL;
                end else if (zero_in) begin
                    zero_go_s = 1'b1;
                    accept_s  = rate_valid_in;
                end else begin
                    flow_s   = 1'b1;
                    accept_s = rate_valid_in;
                end
            end
            ST_CAL: begin
                cal_add_s = rate_valid_in;
                if (rate_valid_in && (cnt_r == CNT_LAST)) begin
                    state_next_s = ST_LOAD;
                end else begin
                    state_next_s = ST_CAL;
                end
            end
            ST_LOAD: begin
                load_s       = 1'b1;
                state_next_s = ST_RUN;
            end
            default: begin
                state_next_s = ST_RUN;
            end
        endcase
    end

    // FSM, calibration counter, valid pipeline and status outputs
    always_ff @(posedge clk_100mhz or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_r <= ST_RUN;
            cnt_r   <= '0;
            v1_r    <= 1'b0;
            v2_r    <= 1'b0;
            valid_r <= 1'b0;
            ready_r <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            if (cal_go_s) begin
                cnt_r <= '0;
            end else if (cal_add_s) begin
                cnt_r <= cnt_r + 1'b1;
            end
            v1_r    <= accept_s;
            v2_r    <= flow_s & v1_r;
            valid_r <= flow_s & v2_r;
            ready_r <= (state_next_s == ST_RUN);
            busy_r  <= (state_next_s != ST_RUN);
        end
    end

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_chan
        gyro_chan #(
            .IN_W       (IN_W),
            .OUT_W      (OUT_W),
            .FRAC_BITS  (FRAC_BITS),
            .GAIN       (GAIN),
            .GAIN_SHIFT (GAIN_SHIFT),
            .CAL_LOG2   (CAL_LOG2),
            .DEADBAND   (DEADBAND)
        ) u_chan (
            .clk       (clk_100mhz),
            .rst_n     (rst_n_in),
            .rate      (rate_in[ch*IN_W +: IN_W]),
            .add_en    (flow_s & v1_r),
            .acc_clr   (zero_go_s | load_s),
            .cal_clr   (cal_go_s),
            .cal_add   (cal_add_s),
            .bias_load (load_s),
            .out_upd   (flow_s & v2_r),
            .out_clr   (zero_go_s | load_s),
            .angle     (angle_out[ch*OUT_W +: OUT_W])
        );
    end

    assign angle_valid_out = valid_r;
    assign ready_out       = ready_r;
    assign cal_busy_out    = busy_r;

endmodule

// File: tb/tb_gyro_integrator.sv
// Self-checking bench for gyro_integrator: directed and random steps against a queue-based reference model.
// Honours GYRO_DEADBAND_EN in the reference model.
module tb_gyro_integrator;

    localparam int NCH   = 3;
    localparam int GAIN  = 6554;
    localparam int SH    = 8;
    localparam int CAL_N = 16;
    localparam int M_RUN = 0;
    localparam int M_CAL = 1;
    localparam int M_LD  = 2;

    logic        clk_100mhz = 1'b0;
    logic        rst_n_in;
    logic [47:0] rate_in;
    logic        rate_valid_in;
    logic        cal_start_in;
    logic        zero_in;
    logic [47:0] angle_out;
    logic        angle_valid_out;
    logic        ready_out;
    logic        cal_busy_out;

    always #5 clk_100mhz = ~clk_100mhz;

    gyro_integrator dut (
        .clk_100mhz      (clk_100mhz),
        .rst_n_in        (rst_n_in),
        .rate_in         (rate_in),
        .rate_valid_in   (rate_valid_in),
        .cal_start_in    (cal_start_in),
        .zero_in         (zero_in),
        .angle_out       (angle_out),
        .angle_valid_out (angle_valid_out),
        .ready_out       (ready_out),
        .cal_busy_out    (cal_busy_out)
    );

    typedef struct packed {
        logic [31:0] due;
        logic [71:0] incs;
    } pend_t;

    int                 checks = 0;
    int                 errors = 0;
    int                 edge_k = 0;
    int                 mode;
    int                 cnt_m;
    int                 sum_m [NCH];
    logic signed [15:0] bias_m [NCH];
    logic        [23:0] acc_m [NCH];
    logic        [15:0] ang_m [NCH];
    logic               exp_valid, exp_ready, exp_busy;
    pend_t              q [$];

    function automatic logic [23:0] model_inc(input int rate, input int bias);
        longint d;
        longint p;
        d = longint'(rate) - longint'(bias);
`ifdef GYRO_DEADBAND_EN
        if (d <= 2 && d >= -2) d = 0;
`endif
        p = (d * GAIN) >>> SH;
        return p[23:0];
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            acc_m[c] = '0; ang_m[c] = '0; bias_m[c] = '0; sum_m[c] = 0;
        end
        cnt_m = 0; mode = M_RUN; q.delete();
        exp_valid = 1'b0; exp_ready = 1'b0; exp_busy = 1'b0;
    endtask

    task automatic model_push(input int r0, input int r1, input int r2);
        pend_t e;
        e.due  = 32'(edge_k + 2);
        e.incs = {model_inc(r2, bias_m[2]), model_inc(r1, bias_m[1]), model_inc(r0, bias_m[0])};
        q.push_back(e);
    endtask

    task automatic model_edge(input bit v, input int r0, input int r1, input int r2,
                              input bit cal, input bit zr);
        pend_t e;
        exp_valid = 1'b0;
        if (mode == M_RUN) begin
            if (cal) begin
                mode = M_CAL; cnt_m = 0; q.delete();
                for (int c = 0; c < NCH; c++) sum_m[c] = 0;
            end else if (zr) begin
                q.delete();
                for (int c = 0; c < NCH; c++) begin acc_m[c] = '0; ang_m[c] = '0; end
                if (v) model_push(r0, r1, r2);
            end else begin
                if (q.size() > 0 && q[0].due == 32'(edge_k)) begin
                    e = q.pop_front();
                    for (int c = 0; c < NCH; c++) begin
                        acc_m[c] = acc_m[c] + e.incs[c*24 +: 24];
                        ang_m[c] = acc_m[c][23:8];
                    end
                    exp_valid = 1'b1;
                end
                if (v) model_push(r0, r1, r2);
            end
        end else if (mode == M_CAL) begin
            if (v) begin
                sum_m[0] += r0; sum_m[1] += r1; sum_m[2] += r2;
                cnt_m++;
                if (cnt_m == CAL_N) mode = M_LD;
            end
        end else begin
            for (int c = 0; c < NCH; c++) begin
                bias_m[c] = 16'(sum_m[c] >>> 4);
                acc_m[c]  = '0;
                ang_m[c]  = '0;
            end
            mode = M_RUN;
        end
        exp_ready = (mode == M_RUN);
        exp_busy  = (mode != M_RUN);
    endtask

    task automatic check_all(input string tag);
        for (int c = 0; c < NCH; c++) begin
            checks++;
            assert (angle_out[c*16 +: 16] === ang_m[c]) else begin
                errors++;
                $error("FAIL %s angle ch%0d: observed %0d expected %0d", tag, c,
                       $signed(angle_out[c*16 +: 16]), $signed(ang_m[c]));
            end
        end
        checks++;
        assert (angle_valid_out === exp_valid) else begin
            errors++;
            $error("FAIL %s angle_valid: observed %0b expected %0b", tag, angle_valid_out, exp_valid);
        end
        checks++;
        assert (ready_out === exp_ready) else begin
            errors++;
            $error("FAIL %s ready: observed %0b expected %0b", tag, ready_out, exp_ready);
        end
        checks++;
        assert (cal_busy_out === exp_busy) else begin
            errors++;
            $error("FAIL %s cal_busy: observed %0b expected %0b", tag, cal_busy_out, exp_busy);
        end
    endtask

    task automatic step(input string tag, input bit v, input int r0, input int r1, input int r2,
                        input bit cal, input bit zr);
        rate_valid_in = v;
        rate_in       = {r2[15:0], r1[15:0], r0[15:0]};
        cal_start_in  = cal;
        zero_in       = zr;
        @(posedge clk_100mhz);
        edge_k++;
        model_edge(v, r0, r1, r2, cal, zr);
        #1;
        check_all(tag);
        rate_valid_in = 1'b0;
        cal_start_in  = 1'b0;
        zero_in       = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step("idle", 1'b0, 0, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        rst_n_in = 1'b0;
        model_reset();
        #1;
        check_all("reset");
        #2;
        rst_n_in = 1'b1;
    endtask

    function automatic int rnd_rate();
        return int'($urandom_range(0, 65535)) - 32768;
    endfunction

    initial begin
        rate_in = '0; rate_valid_in = 1'b0; cal_start_in = 1'b0; zero_in = 1'b0;
        rst_n_in = 1'b0;
        model_reset();
        #2;
        check_all("por");
        #1 rst_n_in = 1'b1;
        idle(2);

        // ten samples of +100 on roll, full throughput
        for (int i = 0; i < 10; i++) step("ten100", 1'b1, 100, 0, 0, 1'b0, 1'b0);
        idle(3);

        // deadband boundary from a cleared angle
        step("zero", 1'b0, 0, 0, 0, 1'b0, 1'b1);
        step("db2", 1'b1, 2, 0, 0, 1'b0, 1'b0);
        idle(3);
        step("db3", 1'b1, 3, -2, 0, 1'b0, 1'b0);
        idle(3);

        // negative sample then long run across the positive wrap
        step("zero", 1'b0, 0, 0, 0, 1'b0, 1'b1);
        step("neg100", 1'b1, -100, 0, 0, 1'b0, 1'b0);
        idle(3);
        for (int i = 0; i < 3278; i++) step("wrap", 1'b1, 100, 0, -100, 1'b0, 1'b0);
        idle(3);

        // in-flight sample discarded by zero, concurrent sample kept
        step("inflight", 1'b1, 500, 7, -9, 1'b0, 1'b0);
        step("zero_drop", 1'b0, 0, 0, 0, 1'b0, 1'b1);
        idle(3);
        step("zero_keep", 1'b1, 300, -300, 40, 1'b0, 1'b1);
        idle(3);

        // reset in the middle of a stream
        step("pre_rst", 1'b1, 1000, 1000, 1000, 1'b0, 1'b0);
        do_reset();
        idle(2);

        // directed calibration, then one corrected sample
        step("cal_go", 1'b1, 999, 999, 999, 1'b1, 1'b1);
        for (int i = 0; i < CAL_N; i++) step("cal", 1'b1, 20, -4, 0, 1'b0, 1'b0);
        step("load", 1'b1, 777, 777, 777, 1'b1, 1'b0);
        step("postcal", 1'b1, 120, -4, 0, 1'b0, 1'b0);
        idle(3);

        // reset mid-calibration must drop the bias back to zero
        step("cal_go2", 1'b0, 0, 0, 0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) step("cal2", 1'b1, 400, 400, 400, 1'b0, 1'b0);
        do_reset();
        idle(1);
        step("nobias", 1'b1, 50, 50, 50, 1'b0, 1'b0);
        idle(3);

        // random traffic with occasional re-zero and calibration requests
        for (int i = 0; i < 600; i++) begin
            step("rand", ($urandom_range(0, 9) < 7), rnd_rate(), rnd_rate(), rnd_rate(),
                 ($urandom_range(0, 99) == 0), ($urandom_range(0, 24) == 0));
        end
        for (int i = 0; i < 40; i++) begin
            step("randcal", 1'b1, int'($urandom_range(0, 200)) - 100, int'($urandom_range(0, 200)) - 100,
                 int'($urandom_range(0, 200)) - 100, (i == 0), 1'b0);
        end
        idle(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
